// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
// Holds the FSM state encoding, requester count, select width and a one-hot helper.
package mux4_rr_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
        return NREQ'(1) << i;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the arbiter.
// master: requester side (drives req); slave: arbiter side (drives gnt/sel/busy/preempt).
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             preempt;

    modport master (
        output req,
        input  gnt, sel, busy, preempt
    );

    modport slave (
        input  req,
        output gnt, sel, busy, preempt
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating priority picker over four requests.
// Ports: req/mask in, ptr = search start; any = a candidate exists, idx = winner.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [NREQ-1:0]  mask,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [NREQ-1:0]  cand;
    logic [SEL_W-1:0] j;

    assign cand = req & ~mask;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // 2-bit add wraps 3->0 naturally
            j = ptr + SEL_W'(k);
            if (!any && cand[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux select with a bounded hold time.
// Ports: clk, reset (sync, active-high), bus (slave): req in; gnt/sel/busy/preempt registered out.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    mux4_rr_arbiter_if.slave bus
);

    // Saturation point; with no limit the counter just parks at all-ones
    localparam logic [CNT_W-1:0] CAP =
        (MAX_HOLD != 0) ? CNT_W'(MAX_HOLD) : '1;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             busy_q;
    logic             pre_q, pre_d;

    logic             any;
    logic [SEL_W-1:0] idx;
    logic [NREQ-1:0]  mask;
    logic             take;
    logic             at_lim;

    // While owning, the owner is never its own successor
    assign mask   = (state_q == ST_OWN) ? onehot(sel_q) : '0;
    assign at_lim = (MAX_HOLD != 0) && (hold_q == CAP);

    rr_pick4 u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .mask (mask),
        .any  (any),
        .idx  (idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        pre_d   = 1'b0;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                take  = any;
            end
            ST_OWN: begin
                if (!bus.req[sel_q]) begin
                    if (any) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end else if (at_lim && any) begin
                    take  = 1'b1;
                    pre_d = 1'b1;
                end else if (hold_q != CAP) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (take) begin
            state_d = ST_OWN;
            gnt_d   = onehot(idx);
            sel_d   = idx;
            ptr_d   = idx + 1'b1;
            hold_d  = CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= |gnt_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = pre_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (MAX_HOLD=8).
// Observed vector is {preempt, busy, sel[1:0], gnt[3:0]}.
module tb_mux4_rr_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mux4_rr_arbiter_if bus();

    mux4_rr_arbiter #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected vector for "owner i granted, no preempt"
    function automatic logic [7:0] own(input int i);
        logic [7:0] v;
        v = 8'b0100_0000;
        v[5:4] = i[1:0];
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {bus.preempt, bus.busy, bus.sel, bus.gnt};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.req = 4'b1111;

        // 1: reset with all requesting, then first grant
        tick();
        chk("rst_a", 8'h00);
        tick();
        chk("rst_b", 8'h00);
        reset = 1'b0;
        tick();
        chk("first", own(0));

        // 2: each owner drops after 2 cycles, rotation 0,1,2,3,0
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold2", own(i));
            bus.req = 4'b1111 & ~(4'b0001 << i);
            tick();
            chk("rot", own((i + 1) % 4));
            bus.req = 4'b1111;
        end

        // 3: hold limit between two requesters
        reset = 1'b1;
        tick();
        chk("rst3", 8'h00);
        reset   = 1'b0;
        bus.req = 4'b0011;
        tick();
        chk("lim0", own(0));
        repeat (7) begin
            tick();
            chk("lim0h", own(0));
        end
        tick();
        chk("pre1", own(1) | 8'h80);
        repeat (7) begin
            tick();
            chk("lim1h", own(1));
        end
        tick();
        chk("pre0", own(0) | 8'h80);

        // 4: lone requester keeps grant, never preempted
        reset = 1'b1;
        tick();
        chk("rst4", 8'h00);
        reset   = 1'b0;
        bus.req = 4'b0100;
        repeat (20) begin
            tick();
            chk("solo", own(2));
        end

        // 5: release to idle, sel holds, then pointer at 3
        bus.req = 4'b0000;
        tick();
        chk("idle_a", 8'b0010_0000);
        tick();
        chk("idle_b", 8'b0010_0000);
        bus.req = 4'b1001;
        tick();
        chk("ptr3", own(3));

        // 6: reset mid-tenure clears outputs and pointer
        bus.req = 4'b0010;
        tick();
        chk("to1", own(1));
        tick();
        chk("mid", own(1));
        reset = 1'b1;
        tick();
        chk("rst6", 8'h00);
        reset   = 1'b0;
        bus.req = 4'b1111;
        tick();
        chk("ptr0", own(0));
        reset = 1'b1;
        tick();
        chk("rst6b", 8'h00);
        reset   = 1'b0;
        bus.req = 4'b0010;
        tick();
        chk("regnt", own(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
